// File: rtl/divmod_pkg.sv
// divmod_pkg
// Shared definitions for the sequential divider slice.
//   divState_t  : controller states (IDLE, CALC, FIX)
//   countWidth  : bits needed to hold a step count from 0 up to WIDTH
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } divState_t;

  // The step counter is loaded with WIDTH itself, so it needs room for
  // the value WIDTH, not just WIDTH-1.
  function automatic int countWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divmod_cu.sv
// divmod_cu
// Control unit for divmod_seq: owns the FSM state and the step counter and
// issues one-cycle strobes that steer the datapath.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start_i    operation request, honoured only in IDLE
//   bZero_i    divisor is zero (valid alongside start_i)
//   load_o     latch operand magnitudes and signs, clear partial remainder
//   step_o     perform one restoring-division step
//   fix_o      apply signs and write the result registers
//   zeroDiv_o  write the divide-by-zero result immediately
//   busy_o     an operation is in flight (CALC or FIX)
module divmod_cu
  import divmod_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic bZero_i,
  output logic load_o,
  output logic step_o,
  output logic fix_o,
  output logic zeroDiv_o,
  output logic busy_o
);

  localparam int CW = countWidth(WIDTH);
  localparam logic [CW-1:0] CountInit = CW'(WIDTH);
  localparam logic [CW-1:0] CountOne  = CW'(1);

  divState_t       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;

  // State and counter registers; reset discards any in-flight operation
  // and also wins over a start presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and strobe decode. A zero divisor never leaves IDLE: the
  // result is known up front, so it is written in the same cycle as the
  // request and busy never rises.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load_o    = 1'b0;
    step_o    = 1'b0;
    fix_o     = 1'b0;
    zeroDiv_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (bZero_i) begin
            zeroDiv_o = 1'b1;
          end else begin
            load_o  = 1'b1;
            count_d = CountInit;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        step_o  = 1'b1;
        count_d = count_q - CountOne;
        // Leaving after the step that takes the count to zero gives
        // exactly WIDTH steps.
        if (count_q == CountOne) begin
          state_d = FIX;
        end
      end
      FIX: begin
        fix_o   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/divmod_seq.sv
// divmod_seq
// Multi-cycle restoring divider producing quotient and remainder together,
// one quotient bit per cycle, with signed/unsigned modes and divide-by-zero
// reporting. Latency is WIDTH+2 cycles; divide by zero answers in 1 cycle.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        request, sampled only when idle
//   is_signed    1 = two's-complement operands (sampled with start)
//   A, B         dividend and divisor (sampled with start)
//   Quotient     registered quotient, held until the next done
//   Remainder    registered remainder, held until the next done
//   busy         operation in flight
//   done         one-cycle pulse when the result registers update
//   div_by_zero  registered with the results, set when B was zero
module divmod_seq
  import divmod_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  logic load, step, fix, zeroDiv, bZero;

  // Working registers: dvd_q starts as the dividend magnitude and fills
  // with quotient bits from the bottom as dividend bits leave the top.
  logic [WIDTH-1:0] rem_q, dvd_q, dvs_q;
  logic             signQuot_q, signRem_q;

  // Result registers.
  logic [WIDTH-1:0] quot_q, remOut_q;
  logic             done_q, dbz_q;

  logic [WIDTH-1:0] absA_d, absB_d, remStep_d, quotFix_d, remFix_d;
  logic [WIDTH:0]   shifted_d, trial_d;
  logic             qBit_d, signQuot_d, signRem_d;

  assign bZero = (B == '0);

  divmod_cu #(.WIDTH(WIDTH)) uCu (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start),
    .bZero_i   (bZero),
    .load_o    (load),
    .step_o    (step),
    .fix_o     (fix),
    .zeroDiv_o (zeroDiv),
    .busy_o    (busy)
  );

  // Operand conditioning. The core divides magnitudes; MIN stays MIN here
  // and is simply read as an unsigned 2^(WIDTH-1), which is why MIN / -1
  // comes out as MIN with a zero remainder without any special handling.
  always_comb begin
    absA_d     = (is_signed && A[WIDTH-1]) ? -A : A;
    absB_d     = (is_signed && B[WIDTH-1]) ? -B : B;
    signQuot_d = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
    signRem_d  = is_signed & A[WIDTH-1];
  end

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value is below twice the divisor and the WIDTH+1-bit
  // difference has a trustworthy sign bit.
  always_comb begin
    shifted_d = {rem_q, dvd_q[WIDTH-1]};
    trial_d   = shifted_d - {1'b0, dvs_q};
    qBit_d    = ~trial_d[WIDTH];
    remStep_d = qBit_d ? trial_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
  end

  // Sign restoration for truncating division: the remainder follows the
  // dividend, the quotient follows the XOR of both operand signs.
  always_comb begin
    quotFix_d = signQuot_q ? -dvd_q : dvd_q;
    remFix_d  = signRem_q  ? -rem_q : rem_q;
  end

  // Working registers advance only on the controller's load/step strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      signQuot_q <= 1'b0;
      signRem_q  <= 1'b0;
    end else if (load) begin
      rem_q      <= '0;
      dvd_q      <= absA_d;
      dvs_q      <= absB_d;
      signQuot_q <= signQuot_d;
      signRem_q  <= signRem_d;
    end else if (step) begin
      rem_q      <= remStep_d;
      dvd_q      <= {dvd_q[WIDTH-2:0], qBit_d};
    end
  end

  // Result registers hold between operations; done pulses for exactly the
  // cycle in which new values first appear.
  always_ff @(posedge clk) begin
    if (reset) begin
      quot_q   <= '0;
      remOut_q <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (zeroDiv) begin
        quot_q   <= '1;
        remOut_q <= A;
        dbz_q    <= 1'b1;
        done_q   <= 1'b1;
      end else if (fix) begin
        quot_q   <= quotFix_d;
        remOut_q <= remFix_d;
        dbz_q    <= 1'b0;
        done_q   <= 1'b1;
      end
    end
  end

  assign Quotient    = quot_q;
  assign Remainder   = remOut_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divmod_seq.sv
// tb_divmod_seq
// Self-checking bench for divmod_seq. Three instances (WIDTH 8, 16, 32)
// share one clock and reset. Expected results come from a plain-arithmetic
// model of truncating division; directed cases cover the worked examples
// and the boundary cases, and a back-to-back random run covers WIDTH=16.
module tb_divmod_seq;

  logic clk = 1'b0;
  logic reset;

  logic        start8, sg8, start16, sg16, start32, sg32;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [31:0] a32, b32;

  wire [7:0]  q8, r8;
  wire [15:0] q16, r16;
  wire [31:0] q32, r32;
  wire        busy8, done8, dbz8, busy16, done16, dbz16, busy32, done32, dbz32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  divmod_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sg8), .A(a8), .B(b8),
    .Quotient(q8), .Remainder(r8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  divmod_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .is_signed(sg16), .A(a16), .B(b16),
    .Quotient(q16), .Remainder(r16), .busy(busy16), .done(done16), .div_by_zero(dbz16)
  );

  divmod_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sg32), .A(a32), .B(b32),
    .Quotient(q32), .Remainder(r32), .busy(busy32), .done(done32), .div_by_zero(dbz32)
  );

  // Reference: truncating division on sign-extended values in 64-bit
  // arithmetic, with the divide-by-zero convention applied first.
  function automatic void refDiv(input int w, input bit s,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic z);
    longint mask, sa, sb;
    mask = (longint'(1) << w) - 1;
    sa   = longint'({32'd0, a}) & mask;
    sb   = longint'({32'd0, b}) & mask;
    if (s && sa[w-1]) sa = sa - (longint'(1) << w);
    if (s && sb[w-1]) sb = sb - (longint'(1) << w);
    if (sb == 0) begin
      q = 32'(mask);
      r = 32'(sa & mask);
      z = 1'b1;
    end else begin
      q = 32'((sa / sb) & mask);
      r = 32'((sa % sb) & mask);
      z = 1'b0;
    end
  endfunction

  function automatic int widthOf(input int k);
    case (k)
      0:       return 8;
      1:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] getQ(input int k);
    case (k)
      0:       return {24'd0, q8};
      1:       return {16'd0, q16};
      default: return q32;
    endcase
  endfunction

  function automatic logic [31:0] getR(input int k);
    case (k)
      0:       return {24'd0, r8};
      1:       return {16'd0, r16};
      default: return r32;
    endcase
  endfunction

  function automatic logic getBusy(input int k);
    case (k)
      0:       return busy8;
      1:       return busy16;
      default: return busy32;
    endcase
  endfunction

  function automatic logic getDone(input int k);
    case (k)
      0:       return done8;
      1:       return done16;
      default: return done32;
    endcase
  endfunction

  function automatic logic getDbz(input int k);
    case (k)
      0:       return dbz8;
      1:       return dbz16;
      default: return dbz32;
    endcase
  endfunction

  task automatic setIn(input int k, input logic st, input logic sg,
                       input logic [31:0] a, input logic [31:0] b);
    case (k)
      0: begin start8 = st;  sg8 = sg;  a8 = a[7:0];   b8 = b[7:0];   end
      1: begin start16 = st; sg16 = sg; a16 = a[15:0]; b16 = b[15:0]; end
      default: begin start32 = st; sg32 = sg; a32 = a; b32 = b; end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one operation on instance k at a falling edge, follow it to done
  // with a bounded wait, and check busy, latency and results. Returns at the
  // falling edge of the done cycle, so a follow-up call starts back-to-back.
  task automatic applyStimulus(input int k, input string tag, input bit s,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic        ez;
    int          lat, w;
    w = widthOf(k);
    refDiv(w, s, a, b, eq, er, ez);
    setIn(k, 1'b1, s, a, b);
    @(negedge clk);
    setIn(k, 1'b0, s, a, b);
    lat = 1;
    while (getDone(k) !== 1'b1 && lat < w + 8) begin
      checkOutput({tag, " busy"}, 32'(getBusy(k)), 32'd1);
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, lat, ez ? 32'd1 : 32'(w + 2));
    checkOutput({tag, " busy@done"}, 32'(getBusy(k)), 32'd0);
    checkOutput({tag, " quotient"}, getQ(k), eq);
    checkOutput({tag, " remainder"}, getR(k), er);
    checkOutput({tag, " dbz"}, 32'(getDbz(k)), 32'(ez));
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] eq, er, lastQ, lastR;
    logic        ez, lastZ, holdOk;
    logic [15:0] ra, rb;
    bit          rs;
    int          lat;

    reset = 1'b1;
    for (int k = 0; k < 3; k++) setIn(k, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset%0d quotient", widthOf(k)), getQ(k), 32'd0);
      checkOutput($sformatf("reset%0d remainder", widthOf(k)), getR(k), 32'd0);
      checkOutput($sformatf("reset%0d busy", widthOf(k)), 32'(getBusy(k)), 32'd0);
      checkOutput($sformatf("reset%0d done", widthOf(k)), 32'(getDone(k)), 32'd0);
      checkOutput($sformatf("reset%0d dbz", widthOf(k)), 32'(getDbz(k)), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed cases, WIDTH=32 and WIDTH=8");
    applyStimulus(2, "u100/7", 1'b0, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    checkOutput("hold quotient", q32, 32'd14);
    checkOutput("hold remainder", r32, 32'd2);
    checkOutput("hold done low", 32'(done32), 32'd0);
    applyStimulus(2, "s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(2, "s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    applyStimulus(2, "u5/0", 1'b0, 32'd5, 32'd0);
    applyStimulus(2, "s5/0", 1'b1, 32'd5, 32'd0);
    applyStimulus(2, "sMIN/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(0, "w8 sMIN/-1", 1'b1, 32'h80, 32'hFF);
    applyStimulus(0, "w8 uFF/1", 1'b0, 32'hFF, 32'h01);
    applyStimulus(0, "w8 s-128/3", 1'b1, 32'h80, 32'h03);

    // A second start while busy must be ignored (its zero divisor would
    // otherwise show up as an early done).
    refDiv(32, 1'b0, 32'd1000, 32'd3, eq, er, ez);
    setIn(2, 1'b1, 1'b0, 32'd1000, 32'd3);
    @(negedge clk);
    setIn(2, 1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    setIn(2, 1'b1, 1'b1, 32'h50, 32'd0);
    @(negedge clk);
    setIn(2, 1'b0, 1'b0, 32'd0, 32'd0);
    lat = 6;
    while (done32 !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("ignore latency", lat, 32'd34);
    checkOutput("ignore quotient", q32, eq);
    checkOutput("ignore remainder", r32, er);
    checkOutput("ignore dbz", 32'(dbz32), 32'd0);

    // Reset in cycle 10 of an operation, with a coincident start.
    setIn(2, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234);
    @(negedge clk);
    setIn(2, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    setIn(2, 1'b1, 1'b0, 32'd9, 32'd3);
    @(negedge clk);
    checkOutput("midreset busy", 32'(busy32), 32'd0);
    checkOutput("midreset done", 32'(done32), 32'd0);
    checkOutput("midreset quotient", q32, 32'd0);
    checkOutput("midreset remainder", r32, 32'd0);
    checkOutput("midreset dbz", 32'(dbz32), 32'd0);
    reset = 1'b0;
    setIn(2, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("postreset busy", 32'(busy32), 32'd0);
    checkOutput("postreset done", 32'(done32), 32'd0);
    applyStimulus(2, "after reset", 1'b0, 32'd9, 32'd3);

    $display("[TB] back-to-back random run, WIDTH=16");
    lastQ = 32'd0;
    lastR = 32'd0;
    lastZ = 1'b0;
    ra = pick16();
    rb = pick16();
    rs = 1'($urandom_range(0, 1));
    refDiv(16, rs, {16'd0, ra}, {16'd0, rb}, eq, er, ez);
    setIn(1, 1'b1, rs, {16'd0, ra}, {16'd0, rb});
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      setIn(1, 1'b0, 1'b0, 32'd0, 32'd0);
      lat = 1;
      holdOk = 1'b1;
      while (done16 !== 1'b1 && lat < 30) begin
        if ({16'd0, q16} !== lastQ || {16'd0, r16} !== lastR || dbz16 !== lastZ)
          holdOk = 1'b0;
        @(negedge clk);
        lat++;
      end
      checkOutput($sformatf("rnd%0d hold", n), 32'(holdOk), 32'd1);
      checkOutput($sformatf("rnd%0d latency", n), lat, ez ? 32'd1 : 32'd18);
      checkOutput($sformatf("rnd%0d quotient", n), {16'd0, q16}, eq);
      checkOutput($sformatf("rnd%0d remainder", n), {16'd0, r16}, er);
      checkOutput($sformatf("rnd%0d dbz", n), 32'(dbz16), 32'(ez));
      lastQ = eq;
      lastR = er;
      lastZ = ez;
      if (n < 999) begin
        ra = pick16();
        rb = pick16();
        rs = 1'($urandom_range(0, 1));
        refDiv(16, rs, {16'd0, ra}, {16'd0, rb}, eq, er, ez);
        setIn(1, 1'b1, rs, {16'd0, ra}, {16'd0, rb});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
